// File: rtl/eu_pkg.sv
// eu_pkg: shared encodings for the parametrised execution unit
package eu_pkg;
  typedef enum logic [1:0] {
    M_ARITH_IMM = 2'b00,
    M_ARITH_REG = 2'b01,
    M_CMP_REG   = 2'b10,
    M_CMP_ZERO  = 2'b11
  } mode_t;
  typedef logic [2:0] state_t;
  localparam logic [1:0] OP_RD_A = 2'b00, OP_RD_B = 2'b01, OP_WR = 2'b10;
  localparam logic [1:0] SEL_ARITH = 2'b10, SEL_CMP = 2'b00;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
                         ALU_XOR = 3'b100, ALU_NOT = 3'b101, ALU_SHL = 3'b110, ALU_SHR = 3'b111;
  localparam state_t S_IDLE = 3'd0, S_DECODE = 3'd1, S_RD_A = 3'd2, S_RD_B = 3'd3,
                     S_EXEC = 3'd4, S_WB = 3'd5, S_DONE = 3'd6;
endpackage

// File: rtl/eu_alu.sv
// eu_alu: combinational DATA_W-wide ALU with carry/borrow and zero outputs
module eu_alu import eu_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_y,
  output logic              o_cout,
  output logic              o_zero
);
  logic [DATA_W:0] w_sum, w_dif;
  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    w_dif = {1'b0, i_a} - {1'b0, i_b};
    o_y = i_op == ALU_ADD ? w_sum[DATA_W-1:0] :
          i_op == ALU_SUB ? w_dif[DATA_W-1:0] :
          i_op == ALU_AND ? i_a & i_b :
          i_op == ALU_OR  ? i_a | i_b :
          i_op == ALU_XOR ? i_a ^ i_b :
          i_op == ALU_NOT ? ~i_a :
          i_op == ALU_SHL ? i_a << 1 : i_a >> 1;
    o_cout = i_op == ALU_ADD ? w_sum[DATA_W] :
             i_op == ALU_SUB ? w_dif[DATA_W] :
             i_op == ALU_SHL ? i_a[DATA_W-1] :
             i_op == ALU_SHR ? i_a[0] : 1'b0;
    o_zero = o_y == '0;
  end
endmodule

// File: rtl/eu_param.sv
// eu_param: execution unit sequencing BIU operand fetch, ALU/compare and write-back
module eu_param import eu_pkg::*; #(
  parameter int DATA_W      = 16,
  parameter int IR_W        = 32,
  parameter int IMM_SIGNED  = 0,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IR_W-1:0]   ir,
  output logic              biu_req,
  output logic [1:0]        biu_sel,
  output logic [1:0]        biu_op,
  input  logic              biu_ack,
  input  logic [DATA_W-1:0] biu_rdata,
  output logic [DATA_W-1:0] biu_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              flag_cout,
  output logic              flag_c,
  output logic              flag_z
);
  localparam int CNT_W = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  state_t             r_state;
  mode_t              r_mode;
  logic [15:0]        r_imm;
  logic [2:0]         r_op;
  logic [DATA_W-1:0]  r_a, r_b, r_result;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err, r_cout, r_c, r_z;
  logic               w_arith, w_two, w_req, w_to, w_cout, w_zero, w_unused;
  logic [DATA_W+15:0] w_ext;
  logic [DATA_W-1:0]  w_b, w_y;
  always_comb begin
    w_arith = r_mode == M_ARITH_IMM || r_mode == M_ARITH_REG;
    w_two = r_mode == M_ARITH_REG || r_mode == M_CMP_REG;
    w_req = r_state == S_RD_A || r_state == S_RD_B || r_state == S_WB;
    w_to = ACK_TIMEOUT > 0 && w_req && !biu_ack && r_cnt == CNT_W'(ACK_TIMEOUT - 1);
    w_ext = IMM_SIGNED != 0 ? {{DATA_W{r_imm[15]}}, r_imm} : {{DATA_W{1'b0}}, r_imm};
    w_b = r_mode == M_ARITH_IMM ? w_ext[DATA_W-1:0] : r_mode == M_CMP_ZERO ? '0 : r_b;
    w_unused = ^{ir, w_ext};
  end
  eu_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a(r_a),
    .i_b(w_b),
    .i_op(r_op),
    .o_y(w_y),
    .o_cout(w_cout),
    .o_zero(w_zero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode <= M_ARITH_IMM;
      r_imm <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_result <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_cout <= 1'b0;
      r_c <= 1'b0;
      r_z <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_cnt <= w_req && !biu_ack ? r_cnt + 1'b1 : '0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mode <= mode_t'(mode);
          r_imm <= ir[15:0];
          r_op <= mode == M_ARITH_IMM ? {1'b0, ir[20:19]} : ir[16:14];
          r_state <= S_DECODE;
        end
        S_DECODE: r_state <= S_RD_A;
        S_RD_A: if (biu_ack) begin
          r_a <= biu_rdata;
          r_state <= w_two ? S_RD_B : S_EXEC;
        end
        S_RD_B: if (biu_ack) begin
          r_b <= biu_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_arith) begin
            r_result <= w_y;
            r_cout <= w_cout;
            r_z <= w_zero;
          end else begin
            r_c <= r_a < w_b;
            r_z <= r_a == w_b;
          end
          r_state <= w_arith ? S_WB : S_DONE;
        end
        S_WB: if (biu_ack) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      if (w_to) begin
        r_state <= S_IDLE;
        r_err <= 1'b1;
      end
    end
  end
  always_comb begin
    biu_req = w_req;
    biu_sel = w_req && w_arith ? SEL_ARITH : SEL_CMP;
    biu_op = r_state == S_RD_B ? OP_RD_B : r_state == S_WB ? OP_WR : OP_RD_A;
    biu_wdata = r_result;
    busy = r_state != S_IDLE && r_state != S_DONE;
    done = r_state == S_DONE;
    err = r_err;
    result = r_result;
    flag_cout = r_cout;
    flag_c = r_c;
    flag_z = r_z;
  end
endmodule
